sram_like_arbiter: RTL and testbench

Two-to-one arbiter that shares one downstream sram-like port between the instruction-cache miss path (`cache_inst_*`) and the data-cache miss/write-through path (`cache_data_*`) of `cache_module`. It sits between `cache_module` and the AXI bridge. It grants the bus to one requester at a time and keeps each grant locked until the address handshake completes. It supports exactly one outstanding transaction and routes the response only to the requester that owns it.

---
 rtl/sram_like_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-to-one inst/data arbiter onto one sram-like port (optional ARB_ROUND_ROBIN_EN)
module sram_like_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok
);

    typedef enum logic [1:0] {IDLE, LOCK, WAIT} state_t;

    state_t state, state_nxt;
    logic   owner_data, owner_data_nxt;   // 1: data side owns the grant/transaction
    logic   grant_data, grant_inst;
    logic   prio_data;                    // data wins a simultaneous request in IDLE

`ifdef ARB_ROUND_ROBIN_EN
    logic last_inst;                      // side that won the most recent address handshake
    logic handshake;

    assign prio_data = last_inst;
    assign handshake = (state != WAIT) && sram_addr_ok && (grant_data || grant_inst);

    // Round-robin pointer follows every completed address handshake
    always_ff @(posedge clk) begin
        if (rst)
            last_inst <= 1'b1;
        else if (handshake)
            last_inst <= grant_inst;
    end
`else
    assign prio_data = 1'b1;
`endif

    // State and owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner_data <= owner_data_nxt;
        end
    end

    // Grant selection and next-state logic
    always_comb begin
        state_nxt      = state;
        owner_data_nxt = owner_data;
        grant_data     = 1'b0;
        grant_inst     = 1'b0;
        case (state)
            IDLE: begin
                grant_data = data_req && (!inst_req || prio_data);
                grant_inst = inst_req && !grant_data;
                if (grant_data || grant_inst) begin
                    owner_data_nxt = grant_data;
                    state_nxt      = sram_addr_ok ? WAIT : LOCK;
                end
            end
            LOCK: begin
                grant_data = owner_data;
                grant_inst = !owner_data;
                if (sram_addr_ok)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (sram_data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Downstream payload mux and upstream handshake routing; all quiet during reset
    always_comb begin
        sram_req     = 1'b0;
        sram_wr      = 1'b0;
        sram_size    = 2'b00;
        sram_addr    = 32'h0;
        sram_wdata   = 32'h0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!rst) begin
            if (grant_data) begin
                sram_req   = data_req;
                sram_wr    = data_wr;
                sram_size  = data_size;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end else if (grant_inst) begin
                sram_req   = inst_req;
                sram_wr    = inst_wr;
                sram_size  = inst_size;
                sram_addr  = inst_addr;
                sram_wdata = inst_wdata;
            end
            // Grants are never asserted in WAIT, so addr_ok is implicitly blocked there
            inst_addr_ok = sram_addr_ok && grant_inst;
            data_addr_ok = sram_addr_ok && grant_data;
            if (state == WAIT) begin
                inst_data_ok = sram_data_ok && !owner_data;
                data_data_ok = sram_data_ok && owner_data;
            end
        end
    end

    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed scoreboard bench for sram_like_arbiter
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, sram_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        sram_req, sram_wr, sram_addr_ok, sram_data_ok;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
    } resp_t;

    resp_t resp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input bit is_data, input logic [31:0] rdata);
        resp_t r;
        r.is_data = is_data;
        r.rdata   = rdata;
        resp_q.push_back(r);
    endtask

    // Drive a downstream response in the current cycle and score it against the queue head
    task automatic respond(input string tag, input logic [31:0] rdata);
        resp_t r;
        sram_data_ok = 1'b1;
        sram_rdata   = rdata;
        #1;
        if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            r = resp_q.pop_front();
            chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(!r.is_data));
            chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(r.is_data));
            chk({tag, "_rdata"}, r.is_data ? data_rdata : inst_rdata, r.rdata);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_sram_req"}, 32'(sram_req), 32'h0);
        chk({tag, "_sram_wr"}, 32'(sram_wr), 32'h0);
        chk({tag, "_sram_size"}, 32'(sram_size), 32'h0);
        chk({tag, "_sram_addr"}, sram_addr, 32'h0);
        chk({tag, "_sram_wdata"}, sram_wdata, 32'h0);
        chk({tag, "_addr_ok"}, {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
        chk({tag, "_data_ok"}, {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h80000000; data_wdata = 32'h12345678;
        sram_addr_ok = 1; sram_data_ok = 0; sram_rdata = 32'h0;
        tick();
        check_quiet("in_reset");
        tick();
        rst = 1'b0; data_req = 0; data_wr = 0; data_addr = 0; data_wdata = 0; sram_addr_ok = 0;
        #1;
        check_quiet("after_reset");

        // Single inst read, addr_ok one cycle late, data_ok two cycles after
        tick();
        inst_req = 1; inst_addr = 32'hBFC00000;
        #1;
        chk("t1_sram_req", 32'(sram_req), 32'h1);
        chk("t1_sram_addr", sram_addr, 32'hBFC00000);
        chk("t1_inst_addr_ok_early", 32'(inst_addr_ok), 32'h0);
        tick();
        sram_addr_ok = 1;
        #1;
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'h1);
        chk("t1_data_addr_ok", 32'(data_addr_ok), 32'h0);
        push_resp(0, 32'h3C080001);
        tick();
        sram_addr_ok = 0; inst_req = 0;
        #1;
        chk("t1_wait_sram_req", 32'(sram_req), 32'h0);
        chk("t1_wait_data_data_ok", 32'(data_data_ok), 32'h0);
        tick();
        respond("t1", 32'h3C080001);
        tick();
        sram_data_ok = 0;

        // Simultaneous inst read and data write: data first
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        #1;
        chk("t2_sram_addr", sram_addr, 32'h80001000);
        chk("t2_sram_wr", 32'(sram_wr), 32'h1);
        chk("t2_sram_wdata", sram_wdata, 32'hDEADBEEF);
        sram_addr_ok = 1;
        #1;
        chk("t2_data_addr_ok", 32'(data_addr_ok), 32'h1);
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
        push_resp(1, 32'h0);
        tick();
        sram_addr_ok = 0; data_req = 0; data_wr = 0;
        #1;
        chk("t2_wait_sram_req", 32'(sram_req), 32'h0);
        chk("t2_wait_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
        tick();
        respond("t2a", 32'h0);
        tick();
        sram_data_ok = 0;
        #1;
        chk("t2_inst_turn_req", 32'(sram_req), 32'h1);
        chk("t2_inst_turn_addr", sram_addr, 32'hBFC00004);
        sram_addr_ok = 1;
        #1;
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 32'h1);
        push_resp(0, 32'h11112222);
        tick();
        sram_addr_ok = 0; inst_req = 0;
        tick();
        respond("t2b", 32'h11112222);
        tick();
        sram_data_ok = 0;

        // Inst locked while data request arrives mid-wait
        inst_req = 1; inst_addr = 32'hBFC00008;
        tick();
        data_req = 1; data_addr = 32'h80002000;
        #1;
        chk("t3_lock_addr0", sram_addr, 32'hBFC00008);
        chk("t3_lock_data_addr_ok0", 32'(data_addr_ok), 32'h0);
        tick();
        chk("t3_lock_addr1", sram_addr, 32'hBFC00008);
        tick();
        sram_addr_ok = 1;
        #1;
        chk("t3_lock_addr2", sram_addr, 32'hBFC00008);
        chk("t3_inst_addr_ok", 32'(inst_addr_ok), 32'h1);
        chk("t3_data_addr_ok", 32'(data_addr_ok), 32'h0);
        push_resp(0, 32'hAAAA5555);
        tick();
        sram_addr_ok = 0; inst_req = 0;
        #1;
        chk("t3_wait_data_addr_ok", 32'(data_addr_ok), 32'h0);
        tick();
        respond("t3a", 32'hAAAA5555);
        tick();
        sram_data_ok = 0;
        #1;
        chk("t3_data_turn_addr", sram_addr, 32'h80002000);
        sram_addr_ok = 1;
        #1;
        chk("t3_data_addr_ok_late", 32'(data_addr_ok), 32'h1);
        push_resp(1, 32'h5555AAAA);
        tick();
        sram_addr_ok = 0; data_req = 0;
        tick();
        respond("t3b", 32'h5555AAAA);
        tick();
        sram_data_ok = 0;

        // Stray data_ok in IDLE is ignored
        sram_data_ok = 1; sram_rdata = 32'hFFFF0000;
        #1;
        chk("t4_stray_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
        tick();
        sram_data_ok = 0;
        data_req = 1; data_addr = 32'h80002004;
        #1;
        chk("t4_still_idle_req", 32'(sram_req), 32'h1);
        chk("t4_still_idle_addr", sram_addr, 32'h80002004);
        data_req = 0;
        tick();

        // Reset while a transaction is outstanding
        data_req = 1; data_addr = 32'h80003000; sram_addr_ok = 1;
        #1;
        chk("t5_addr_ok", 32'(data_addr_ok), 32'h1);
        tick();
        data_req = 0; sram_addr_ok = 0; rst = 1;
        tick();
        rst = 0;
        #1;
        check_quiet("t5_after_reset");
        sram_data_ok = 1; sram_rdata = 32'h0BADF00D;
        #1;
        chk("t5_late_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
        tick();
        sram_data_ok = 0;
        data_req = 1; data_addr = 32'h80003004; sram_addr_ok = 1;
        #1;
        chk("t5_fresh_addr_ok", 32'(data_addr_ok), 32'h1);
        push_resp(1, 32'hCAFEF00D);
        tick();
        data_req = 0; sram_addr_ok = 0;
        tick();
        respond("t5", 32'hCAFEF00D);
        tick();
        sram_data_ok = 0;

        // Continuous contention for four transactions, starting from a fresh reset
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            bit exp_data;
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = (i % 2) == 0;
`else
            exp_data = 1'b1;
`endif
            inst_req = 1; inst_addr = 32'hBFC01000 + 32'(i * 4);
            data_req = 1; data_addr = 32'h80004000 + 32'(i * 4);
            #1;
            chk($sformatf("t6_%0d_addr", i), sram_addr, exp_data ? data_addr : inst_addr);
            sram_addr_ok = 1;
            #1;
            chk($sformatf("t6_%0d_addr_ok", i), {30'h0, inst_addr_ok, data_addr_ok},
                exp_data ? 32'h1 : 32'h2);
            push_resp(exp_data, 32'h60000000 + 32'(i));
            tick();
            sram_addr_ok = 0;
            tick();
            respond($sformatf("t6_%0d", i), 32'h60000000 + 32'(i));
            tick();
            sram_data_ok = 0;
        end
        inst_req = 0; data_req = 0;

        chk("queue_drained", 32'(resp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
